// File: rtl/sort_result_streamer.sv
// Captures a settled sorter array and streams it out largest-first over a
// valid/ready handshake, flagging a timeout if the array never settles.
module sort_result_streamer #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DEPTH   = 5,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [WIDTH*DEPTH-1:0] in_data,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IdxW-1:0] IdxMax = IdxW'(DEPTH - 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StWait   = 2'd1;
    localparam logic [1:0] StStream = 2'd2;
    localparam logic [1:0] StFinish = 2'd3;

    logic [1:0]             state_q, state_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [WIDTH*DEPTH-1:0] buf_q, buf_d;
    logic [WIDTH*DEPTH-1:0] snap_q, snap_d;
    logic                   err_q, err_d;
    logic                   sorted;
    logic                   stable;

    always_comb begin
        sorted = 1'b1;
        for (int k = 1; k < int'(DEPTH); k++) begin
            if (in_data[k*WIDTH +: WIDTH] < in_data[(k-1)*WIDTH +: WIDTH]) begin
                sorted = 1'b0;
            end
        end
    end

    // Stable means sorted and identical to the previous cycle's sample.
    assign stable = sorted && (in_data == snap_q);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        snap_d  = snap_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    err_d   = 1'b0;
                    snap_d  = in_data;
                    cnt_d   = '0;
                    state_d = StWait;
                end
            end
            StWait: begin
                snap_d = in_data;
                if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + CntW'(1);
                end
                if (stable) begin
                    buf_d   = in_data;
                    idx_d   = IdxMax;
                    state_d = StStream;
                end else if (cnt_q == CntMax) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StStream: begin
                if (out_ready) begin
                    if (idx_q == '0) begin
                        state_d = StFinish;
                    end else begin
                        idx_d = idx_q - IdxW'(1);
                    end
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
            snap_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            snap_q  <= snap_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        out_valid = (state_q == StStream);
        out_last  = (state_q == StStream) && (idx_q == '0);
        out_data  = (state_q == StStream) ? buf_q[32'(idx_q)*WIDTH +: WIDTH] : '0;
        busy      = (state_q != StIdle);
        done      = (state_q == StFinish);
        err       = err_q;
    end

endmodule

// File: tb/tb_sort_result_streamer.sv
// Directed bench for sort_result_streamer: capture, stall, timeout, ignored
// start, mid-stream reset and equal-value streaming.
module tb_sort_result_streamer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [39:0] in_data;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        err;

    int errors = 0;
    int checks = 0;

    sort_result_streamer #(
        .WIDTH   (8),
        .DEPTH   (5),
        .TIMEOUT (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_data   (in_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [39:0] pack5(input logic [7:0] e4, input logic [7:0] e3,
                                          input logic [7:0] e2, input logic [7:0] e1,
                                          input logic [7:0] e0);
        return {e4, e3, e2, e1, e0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // exp_flat holds the expected stream order, first element in the top byte.
    task automatic drain(input logic [39:0] exp_flat, input bit stall, input bit poke);
        int n = 0;
        int cyc = 0;
        logic [7:0] e;
        while (n < 5 && cyc < 60) begin
            out_ready = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            start = poke && (cyc == 1);
            e = exp_flat[(4-n)*8 +: 8];
            check("stream_valid", 32'(out_valid), 32'd1);
            check("stream_data", 32'(out_data), 32'(e));
            check("stream_last", 32'(out_last), 32'(n == 4));
            if (out_valid && out_ready) n++;
            step();
            cyc++;
        end
        start = 1'b0;
        out_ready = 1'b0;
        check("stream_count", 32'(n), 32'd5);
        check("done_pulse", 32'(done), 32'd1);
        check("finish_valid", 32'(out_valid), 32'd0);
        step();
        check("done_clear", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int waitc;
        bit saw_valid;
        rst = 1'b0;
        start = 1'b0;
        out_ready = 1'b0;
        in_data = pack5(8'h08, 8'h10, 8'h13, 8'h45, 8'h01);
        #1 rst = 1'b1;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        step();
        step();
        rst = 1'b0;
        step();
        check("idle_after_rst", 32'(busy), 32'd0);

        // Unsorted array that later settles.
        start = 1'b1;
        step();
        start = 1'b0;
        check("wait_busy", 32'(busy), 32'd1);
        check("wait_valid", 32'(out_valid), 32'd0);
        step();
        step();
        check("unsorted_valid", 32'(out_valid), 32'd0);
        in_data = pack5(8'h45, 8'h13, 8'h10, 8'h08, 8'h01);
        step();
        check("first_sample_valid", 32'(out_valid), 32'd0);
        step();
        drain({8'h45, 8'h13, 8'h10, 8'h08, 8'h01}, 1'b0, 1'b0);

        // Back-pressure, with in_data scrambled after capture.
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        in_data = pack5(8'h01, 8'h02, 8'h03, 8'h04, 8'h05);
        drain({8'h45, 8'h13, 8'h10, 8'h08, 8'h01}, 1'b1, 1'b0);

        // Array never sorts: timeout.
        start = 1'b1;
        step();
        start = 1'b0;
        waitc = 0;
        saw_valid = 1'b0;
        while (busy && waitc < 40) begin
            if (out_valid) saw_valid = 1'b1;
            waitc++;
            step();
        end
        check("timeout_cycles", 32'(waitc), 32'd32);
        check("timeout_no_valid", 32'(saw_valid), 32'd0);
        check("timeout_err", 32'(err), 32'd1);
        check("timeout_idle", 32'(busy), 32'd0);
        repeat (8) step();
        check("err_sticky", 32'(err), 32'd1);
        check("idle_valid", 32'(out_valid), 32'd0);

        // Start during stream is ignored; accepted start clears err.
        in_data = pack5(8'h45, 8'h13, 8'h10, 8'h08, 8'h01);
        start = 1'b1;
        step();
        start = 1'b0;
        check("err_cleared", 32'(err), 32'd0);
        step();
        drain({8'h45, 8'h13, 8'h10, 8'h08, 8'h01}, 1'b0, 1'b1);
        step();
        check("no_restart", 32'(busy), 32'd0);

        // Asynchronous reset after two transfers.
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        out_ready = 1'b1;
        step();
        step();
        check("third_elem", 32'(out_data), 32'h10);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_data", 32'(out_data), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_last", 32'(out_last), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_err", 32'(err), 32'd0);
        out_ready = 1'b0;
        step();
        rst = 1'b0;
        step();
        check("post_rst_idle", 32'(busy), 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        drain({8'h45, 8'h13, 8'h10, 8'h08, 8'h01}, 1'b0, 1'b0);

        // Constant, already-sorted array with equal values.
        in_data = pack5(8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00);
        start = 1'b1;
        step();
        start = 1'b0;
        check("eq_wait_valid", 32'(out_valid), 32'd0);
        check("eq_wait_busy", 32'(busy), 32'd1);
        step();
        check("eq_stream_valid", 32'(out_valid), 32'd1);
        check("eq_stream_first", 32'(out_data), 32'hFF);
        drain({8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
